// File: rtl/led_bank_scheduler_pkg.sv
// Shared types, sizes and arbitration helpers for the LED bank scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int NUM_REQ   = 3;
  localparam int LED_WIDTH = 8;
  localparam logic [LED_WIDTH-1:0] LED_OFF = 8'hFF;

  // Advance a requester index by one, wrapping modulo NUM_REQ.
  function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Round-robin search: first set request bit starting at 'start', wrapping.
  // Returns 'start' when nothing is requested; callers gate with |req.
  function automatic logic [1:0] next_owner(input logic [NUM_REQ-1:0] req,
                                            input logic [1:0]         start);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    idx   = start;
    win   = start;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win   = (!found && req[idx]) ? idx : win;
      found = found | req[idx];
      idx   = inc_mod3(idx);
    end
    return win;
  endfunction

  // Index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/led_bank_scheduler_if.sv
// Request/pattern/grant bundle between the pattern sources and the scheduler.
interface led_bank_scheduler_if;
  import led_sched_pkg::*;

  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0][LED_WIDTH-1:0] pattern;
  logic [NUM_REQ-1:0]                grant;
  logic [LED_WIDTH-1:0]              led;
  logic                              busy;

  modport master (output req, pattern, input grant, led, busy);
  modport slave  (input req, pattern, output grant, led, busy);
endinterface

// File: rtl/led_bank_scheduler_tick_prescaler.sv
// Reloadable down-counter producing the slot time base; tick is the cycle
// in which the count reaches zero, so a reload on state entry makes slot
// and gap lengths exact multiples of PRESCALE.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk_12mhz,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);
  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] RELOAD_VAL = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_r;

  // Count down, reloading on request or after the zero cycle.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (reload) begin
      cnt_r <= RELOAD_VAL;
    end else if (cnt_r == '0) begin
      cnt_r <= RELOAD_VAL;
    end else begin
      cnt_r <= cnt_r - CW'(1);
    end
  end

  assign tick = (cnt_r == '0);
endmodule

// File: rtl/led_bank_scheduler.sv
// Round-robin time-slicing of one active-low 8-LED bank between three
// pattern sources: each owner holds the bank for HOLD_TICKS, then the bank
// goes dark for GAP_TICKS before the next arbitration.
module led_bank_scheduler
  import led_sched_pkg::*;
#(
  parameter real CLK_FREQUENCY  = 12.0e6,
  parameter real TICK_FREQUENCY = 1.0e3,
  parameter int  HOLD_TICKS     = 500,
  parameter int  GAP_TICKS      = 10
) (
  input  logic                 clk_12mhz,
  input  logic                 rst_n,
  led_bank_scheduler_if.slave  bus
);
  localparam int PRESCALE  = int'(CLK_FREQUENCY / TICK_FREQUENCY);
  localparam int MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int TCW       = $clog2(MAX_TICKS + 1);

  state_t               state_r;
  logic [1:0]           owner_r;
  logic [1:0]           rr_ptr_r;
  logic [TCW-1:0]       tick_cnt_r;
  logic [NUM_REQ-1:0]   grant_r;
  logic [LED_WIDTH-1:0] led_r;
  logic                 busy_r;

  state_t     next_state_s;
  logic [1:0] win_s;
  logic       any_req_s;
  logic       hold_done_s;
  logic       gap_done_s;
  logic       release_s;
  logic       reload_s;
  logic       arbitrate_s;
  logic       tick_s;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_12mhz (clk_12mhz),
    .rst_n     (rst_n),
    .reload    (reload_s),
    .tick      (tick_s)
  );

  // Next-state decision and arbitration result for the current cycle.
  always_comb begin
    any_req_s    = |bus.req;
    win_s        = next_owner(bus.req, rr_ptr_r);
    hold_done_s  = tick_s && (tick_cnt_r == TCW'(HOLD_TICKS - 1));
    gap_done_s   = tick_s && (tick_cnt_r == TCW'(GAP_TICKS - 1));
    release_s    = !bus.req[owner_r];
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) next_state_s = HOLD;
        else           next_state_s = IDLE;
      end
      HOLD: begin
        // Expiry and release in the same cycle collapse to one transition.
        if (hold_done_s || release_s) next_state_s = GAP;
        else                          next_state_s = HOLD;
      end
      GAP: begin
        if (gap_done_s) next_state_s = any_req_s ? HOLD : IDLE;
        else            next_state_s = GAP;
      end
      default: next_state_s = IDLE;
    endcase
    // Time base restarts on every entry; held in reload while idle.
    reload_s    = (next_state_s != state_r) || (state_r == IDLE);
    arbitrate_s = (state_r != HOLD) && (next_state_s == HOLD);
  end

  // Controller state, ownership and registered LED/grant/busy outputs.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      owner_r  <= 2'd0;
      rr_ptr_r <= 2'd0;
      grant_r  <= 3'b000;
      led_r    <= LED_OFF;
      busy_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE, GAP: begin
          if (arbitrate_s) begin
            owner_r <= win_s;
            grant_r <= to_onehot(win_s);
            led_r   <= ~bus.pattern[win_s];
            busy_r  <= 1'b1;
          end else begin
            grant_r <= 3'b000;
            led_r   <= LED_OFF;
            busy_r  <= (next_state_s == GAP);
          end
        end
        HOLD: begin
          if (next_state_s == GAP) begin
            grant_r  <= 3'b000;
            led_r    <= LED_OFF;
            busy_r   <= 1'b1;
            rr_ptr_r <= inc_mod3(owner_r);
          end else begin
            led_r    <= ~bus.pattern[owner_r];
            busy_r   <= 1'b1;
          end
        end
        default: begin
          owner_r  <= 2'd0;
          rr_ptr_r <= 2'd0;
          grant_r  <= 3'b000;
          led_r    <= LED_OFF;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  // Ticks elapsed in the current state; cleared on every state entry.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
    end else if (reload_s) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= tick_cnt_r + TCW'(1);
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  assign bus.grant = grant_r;
  assign bus.led   = led_r;
  assign bus.busy  = busy_r;
endmodule

// File: tb/tb_led_bank_scheduler.sv
// Directed bench for led_bank_scheduler: PRESCALE=4, HOLD_TICKS=3,
// GAP_TICKS=2, so a slot is 12 cycles and a gap is 8 cycles.
module tb_led_bank_scheduler;
  import led_sched_pkg::*;

  logic clk_12mhz;
  logic rst_n;
  int   vectors;
  int   errors;

  led_bank_scheduler_if bus_if ();

  led_bank_scheduler #(
    .CLK_FREQUENCY  (1000.0),
    .TICK_FREQUENCY (250.0),
    .HOLD_TICKS     (3),
    .GAP_TICKS      (2)
  ) dut (
    .clk_12mhz (clk_12mhz),
    .rst_n     (rst_n),
    .bus       (bus_if)
  );

  initial clk_12mhz = 1'b0;
  always #5 clk_12mhz = ~clk_12mhz;

  typedef struct {
    logic [2:0] req;
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] p2;
    int         cycles;
    logic [2:0] g;
    logic [7:0] l;
    logic       b;
  } seg_t;

  seg_t segs[$];

  task automatic chk(input string name, input logic [2:0] g,
                     input logic [7:0] l, input logic b);
    vectors++;
    if (bus_if.grant !== g || bus_if.led !== l || bus_if.busy !== b) begin
      errors++;
      $display("FAIL %s @%0t: got grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
               name, $time, bus_if.grant, bus_if.led, bus_if.busy, g, l, b);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [7:0] p0,
                       input logic [7:0] p1, input logic [7:0] p2);
    bus_if.req        = r;
    bus_if.pattern[0] = p0;
    bus_if.pattern[1] = p1;
    bus_if.pattern[2] = p2;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    drive(3'b000, 8'h00, 8'h00, 8'h00);

    // Single requester, then idle, then three-way round-robin.
    segs.push_back('{3'b000, 8'h0F, 8'h00, 8'h00,  3, 3'b000, 8'hFF, 1'b0});
    segs.push_back('{3'b001, 8'h0F, 8'h00, 8'h00, 12, 3'b001, 8'hF0, 1'b1});
    segs.push_back('{3'b001, 8'h0F, 8'h00, 8'h00,  8, 3'b000, 8'hFF, 1'b1});
    segs.push_back('{3'b001, 8'h0F, 8'h00, 8'h00, 12, 3'b001, 8'hF0, 1'b1});
    segs.push_back('{3'b000, 8'h0F, 8'h00, 8'h00,  8, 3'b000, 8'hFF, 1'b1});
    segs.push_back('{3'b000, 8'h0F, 8'h00, 8'h00,  2, 3'b000, 8'hFF, 1'b0});
    segs.push_back('{3'b111, 8'h01, 8'h02, 8'h04, 12, 3'b010, 8'hFD, 1'b1});
    segs.push_back('{3'b111, 8'h01, 8'h02, 8'h04,  8, 3'b000, 8'hFF, 1'b1});
    segs.push_back('{3'b111, 8'h01, 8'h02, 8'h04, 12, 3'b100, 8'hFB, 1'b1});
    segs.push_back('{3'b111, 8'h01, 8'h02, 8'h04,  8, 3'b000, 8'hFF, 1'b1});
    segs.push_back('{3'b111, 8'h01, 8'h02, 8'h04, 12, 3'b001, 8'hFE, 1'b1});
    segs.push_back('{3'b111, 8'h01, 8'h02, 8'h04,  8, 3'b000, 8'hFF, 1'b1});
    segs.push_back('{3'b111, 8'h01, 8'h02, 8'h04, 12, 3'b010, 8'hFD, 1'b1});
    segs.push_back('{3'b000, 8'h01, 8'h02, 8'h04,  8, 3'b000, 8'hFF, 1'b1});
    segs.push_back('{3'b000, 8'h01, 8'h02, 8'h04,  2, 3'b000, 8'hFF, 1'b0});

    // Reset state.
    repeat (2) @(negedge clk_12mhz);
    chk("reset_state", 3'b000, 8'hFF, 1'b0);
    rst_n = 1'b1;

    // Table-driven segments: inputs set at a negedge, checked every negedge.
    for (int s = 0; s < segs.size(); s++) begin
      drive(segs[s].req, segs[s].p0, segs[s].p1, segs[s].p2);
      for (int c = 0; c < segs[s].cycles; c++) begin
        @(negedge clk_12mhz);
        chk($sformatf("seg%0d_cyc%0d", s, c), segs[s].g, segs[s].l, segs[s].b);
      end
    end

    // Early release: rr_ptr is 2, so source 2 wins; drop after 5 cycles.
    drive(3'b101, 8'h01, 8'h02, 8'h04);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_12mhz);
      chk("early_hold", 3'b100, 8'hFB, 1'b1);
    end
    drive(3'b001, 8'h01, 8'h02, 8'h04);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_12mhz);
      chk("early_gap", 3'b000, 8'hFF, 1'b1);
    end
    @(negedge clk_12mhz);
    chk("early_next_owner", 3'b001, 8'hFE, 1'b1);

    // Release coinciding with the third tick: single gap of 8 cycles.
    for (int c = 0; c < 11; c++) begin
      @(negedge clk_12mhz);
      chk("expiry_hold", 3'b001, 8'hFE, 1'b1);
    end
    drive(3'b000, 8'h01, 8'h02, 8'h04);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_12mhz);
      chk("expiry_gap", 3'b000, 8'hFF, 1'b1);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_12mhz);
      chk("expiry_idle", 3'b000, 8'hFF, 1'b0);
    end

    // Pattern tracking: rr_ptr is 1, source 1 owns.
    drive(3'b010, 8'h01, 8'h01, 8'h04);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_12mhz);
      chk("pat_before", 3'b010, 8'hFE, 1'b1);
    end
    drive(3'b010, 8'h55, 8'h80, 8'h04);
    @(negedge clk_12mhz);
    chk("pat_after", 3'b010, 8'h7F, 1'b1);
    drive(3'b010, 8'hAA, 8'h80, 8'h33);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_12mhz);
      chk("pat_nonowner", 3'b010, 8'h7F, 1'b1);
    end

    // Asynchronous reset mid-HOLD, then rr_ptr must be back at 0.
    rst_n = 1'b0;
    #1;
    chk("reset_async", 3'b000, 8'hFF, 1'b0);
    @(negedge clk_12mhz);
    chk("reset_held", 3'b000, 8'hFF, 1'b0);
    rst_n = 1'b1;
    drive(3'b011, 8'h01, 8'h02, 8'h04);
    @(negedge clk_12mhz);
    chk("reset_rr_ptr", 3'b001, 8'hFE, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
